// File: rtl/risc_v_mem_map_pkg.sv
// Data-memory address map shared by the core-side decode logic: MMIO addresses,
// ERR bit positions and the decoded-region type.
package risc_v_mem_map_pkg;

    localparam logic [31:0] RAM_BASE      = 32'h1001_0000;
    localparam logic [31:0] GPIO_OUT_ADDR = 32'h1000_0024;
    localparam logic [31:0] GPIO_IN_ADDR  = 32'h1000_0028;
    localparam logic [31:0] CYCLE_ADDR    = 32'h1000_002C;
    localparam logic [31:0] ERR_ADDR      = 32'h1000_0030;

    localparam int ERR_MISALIGNED = 0;
    localparam int ERR_UNMAPPED   = 1;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_GPIO_OUT,
        REG_GPIO_IN,
        REG_CYCLE,
        REG_ERR,
        REG_NONE
    } region_t;

endpackage

// File: rtl/data_memory_responder_data_ram.sv
// Single-port word RAM: asynchronous read, write on the rising edge.
module data_ram #(
    parameter int depth      = 64,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory target: word RAM plus GPIO/CYCLE/ERR MMIO window, combinational reads.
// Define DATA_MEM_CYCLE_COUNTER_EN to build the CYCLE register; otherwise its address is unmapped.
module data_memory_responder
    import risc_v_mem_map_pkg::*;
#(
    parameter int memory_depth = 64,
    parameter int gpio_width   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [31:0]           data_address,
    input  logic [31:0]           writedata,
    output logic [31:0]           received_data,
    input  logic [gpio_width-1:0] gpio_in,
    output logic [gpio_width-1:0] gpio_out,
    output logic                  error_irq
);

    localparam int          ram_addr_width = $clog2(memory_depth);
    localparam logic [31:0] ram_bytes      = 32'(4 * memory_depth);

    logic [31:0]               word_address;
    logic [31:0]               ram_offset;
    logic [ram_addr_width-1:0] ram_index;
    logic [31:0]               ram_rdata;
    region_t                   region;
    logic                      misaligned;
    logic                      strobe;
    logic                      write_ok;
    logic [1:0]                err_set;
    logic [1:0]                err_clr;
    logic [1:0]                err_reg;
    logic [1:0]                err_next;
    logic [gpio_width-1:0]     gpio_out_reg;
    logic [gpio_width-1:0]     gpio_sync1_reg;
    logic [gpio_width-1:0]     gpio_sync2_reg;

    // Region is decoded on the word address so a misaligned hit can still count as mapped.
    assign word_address = {data_address[31:2], 2'b00};
    assign ram_offset   = word_address - RAM_BASE;
    assign ram_index    = ram_offset[ram_addr_width+1:2];
    assign misaligned   = (data_address[1:0] != 2'b00);
    assign strobe       = memread | memwrite;
    assign write_ok     = memwrite & ~misaligned;

    always_comb begin
        region = REG_NONE;
        if ((word_address >= RAM_BASE) && (ram_offset < ram_bytes)) begin
            region = REG_RAM;
        end else begin
            case (word_address)
                GPIO_OUT_ADDR: region = REG_GPIO_OUT;
                GPIO_IN_ADDR:  region = REG_GPIO_IN;
`ifdef DATA_MEM_CYCLE_COUNTER_EN
                CYCLE_ADDR:    region = REG_CYCLE;
`endif
                ERR_ADDR:      region = REG_ERR;
                default:       region = REG_NONE;
            endcase
        end
    end

    // Gating with reset drops a RAM write that coincides with an asynchronous reset.
    data_ram #(
        .depth      (memory_depth),
        .addr_width (ram_addr_width)
    ) u_data_ram (
        .clk   (clk),
        .we    (write_ok && (region == REG_RAM) && !reset),
        .addr  (ram_index),
        .wdata (writedata),
        .rdata (ram_rdata)
    );

    assign err_set[ERR_MISALIGNED] = strobe & misaligned;
    assign err_set[ERR_UNMAPPED]   = strobe & (region == REG_NONE);
    assign err_clr = (write_ok && (region == REG_ERR)) ? writedata[1:0] : 2'b00;

    // Set has priority over write-1-to-clear on each bit.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_err_bit
            assign err_next[gi] = err_set[gi] | (err_reg[gi] & ~err_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg        <= '0;
            gpio_out_reg   <= '0;
            gpio_sync1_reg <= '0;
            gpio_sync2_reg <= '0;
        end else begin
            err_reg        <= err_next;
            gpio_sync1_reg <= gpio_in;
            gpio_sync2_reg <= gpio_sync1_reg;
            if (write_ok && (region == REG_GPIO_OUT)) begin
                gpio_out_reg <= writedata[gpio_width-1:0];
            end
        end
    end

`ifdef DATA_MEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_reg;
    logic [31:0] cycle_next;

    assign cycle_next = (write_ok && (region == REG_CYCLE)) ? 32'd0 : cycle_reg + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_reg <= '0;
        end else begin
            cycle_reg <= cycle_next;
        end
    end
`endif

    always_comb begin
        received_data = '0;
        if (memread && !misaligned) begin
            case (region)
                REG_RAM:      received_data = ram_rdata;
                REG_GPIO_OUT: received_data = {{(32-gpio_width){1'b0}}, gpio_out_reg};
                REG_GPIO_IN:  received_data = {{(32-gpio_width){1'b0}}, gpio_sync2_reg};
`ifdef DATA_MEM_CYCLE_COUNTER_EN
                REG_CYCLE:    received_data = cycle_reg;
`endif
                REG_ERR:      received_data = {30'd0, err_reg};
                default:      received_data = '0;
            endcase
        end
    end

    assign gpio_out  = gpio_out_reg;
    assign error_irq = |err_reg;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed vector table, multi-cycle
// sequences, and random traffic against an address-map reference model.
module tb_data_memory_responder;

    localparam logic [31:0] A_RAM   = 32'h1001_0000;
    localparam logic [31:0] A_GOUT  = 32'h1000_0024;
    localparam logic [31:0] A_GIN   = 32'h1000_0028;
    localparam logic [31:0] A_CYC   = 32'h1000_002C;
    localparam logic [31:0] A_ERR   = 32'h1000_0030;
`ifdef DATA_MEM_CYCLE_COUNTER_EN
    localparam bit          CYC_EN  = 1'b1;
`else
    localparam bit          CYC_EN  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] data_address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] received_data;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic        error_irq;

    always #5 clk = ~clk;

    data_memory_responder #(
        .memory_depth (64),
        .gpio_width   (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .memread       (memread),
        .memwrite      (memwrite),
        .data_address  (data_address),
        .writedata     (writedata),
        .received_data (received_data),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .error_irq     (error_irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_ram [64];
    logic [7:0]  m_gout, m_s1, m_s2;
    logic [31:0] m_cycle;
    logic [1:0]  m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_in_ram(input logic [31:0] w);
        return (w >= A_RAM) && (w < A_RAM + 32'd256);
    endfunction

    function automatic bit m_mapped(input logic [31:0] w);
        return m_in_ram(w) || w == A_GOUT || w == A_GIN || w == A_ERR || (CYC_EN && w == A_CYC);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (a[1:0] != 2'b00) return 32'd0;
        if (m_in_ram(w)) return m_ram[int'((w - A_RAM) >> 2)];
        if (w == A_GOUT) return {24'd0, m_gout};
        if (w == A_GIN) return {24'd0, m_s2};
        if (w == A_CYC && CYC_EN) return m_cycle;
        if (w == A_ERR) return {30'd0, m_err};
        return 32'd0;
    endfunction

    task automatic m_reset();
        m_gout = '0; m_s1 = '0; m_s2 = '0; m_cycle = '0; m_err = '0;
    endtask

    task automatic m_commit(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [7:0] gin);
        logic [31:0] w;
        logic [1:0]  set, clr;
        bit          mis, map;
        w = {a[31:2], 2'b00};
        mis = (a[1:0] != 2'b00);
        map = m_mapped(w);
        set = 2'b00;
        clr = 2'b00;
        if ((rd || wr) && mis) set[0] = 1'b1;
        if ((rd || wr) && !map) set[1] = 1'b1;
        m_cycle = m_cycle + 32'd1;
        if (wr && !mis && map) begin
            if (m_in_ram(w)) m_ram[int'((w - A_RAM) >> 2)] = wd;
            else if (w == A_GOUT) m_gout = wd[7:0];
            else if (w == A_CYC) m_cycle = 32'd0;
            else if (w == A_ERR) clr = wd[1:0];
        end
        m_err = (m_err & ~clr) | set;
        m_s2 = m_s1;
        m_s1 = gin;
    endtask

    // One bus cycle: drive just after a rising edge, sample at the falling edge, commit the model.
    task automatic step(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [7:0] gin, output logic [31:0] got);
        memread = rd; memwrite = wr; data_address = a; writedata = wd; gpio_in = gin;
        @(negedge clk);
        check("rdata", received_data, rd ? m_read(a) : 32'd0);
        check("gpio_out", {24'd0, gpio_out}, {24'd0, m_gout});
        check("error_irq", {31'd0, error_irq}, {31'd0, |m_err});
        got = received_data;
        @(posedge clk);
        m_commit(rd, wr, a, wd, gin);
        #1;
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [21];
    logic [31:0] got;
    logic [7:0]  gin_now;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 1'b0, 32'h1001_000C, 32'h0, 32'h1000_0003};
        tbl[3]  = '{1'b0, 1'b1, 32'h1001_0000, 32'h11, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, 32'h1001_0000, 32'h22, 32'h11};
        tbl[5]  = '{1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'h22};
        tbl[6]  = '{1'b0, 1'b1, A_GOUT, 32'hA5, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, A_GOUT, 32'h0, 32'hA5};
        tbl[8]  = '{1'b0, 1'b1, 32'h1001_0002, 32'h99, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, A_ERR, 32'h0, 32'h1};
        tbl[10] = '{1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'h22};
        tbl[11] = '{1'b0, 1'b1, A_ERR, 32'h1, 32'h0};
        tbl[12] = '{1'b1, 1'b0, A_ERR, 32'h0, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 32'h2000_0000, 32'h0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, A_ERR, 32'h0, 32'h2};
        tbl[15] = '{1'b0, 1'b1, A_ERR, 32'h2, 32'h0};
        tbl[16] = '{1'b0, 1'b1, A_CYC, 32'h1234, 32'h0};
        tbl[17] = '{1'b1, 1'b0, A_CYC, 32'h0, 32'h0};
        tbl[18] = '{1'b1, 1'b0, A_ERR, 32'h0, CYC_EN ? 32'h0 : 32'h2};
        tbl[19] = '{1'b0, 1'b1, A_ERR, 32'h3, 32'h0};
        tbl[20] = '{1'b1, 1'b0, A_ERR, 32'h0, 32'h0};

        // Reset state
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rdata", received_data, 32'd0);
        check("reset_gpio_out", {24'd0, gpio_out}, 32'd0);
        check("reset_irq", {31'd0, error_irq}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // CYCLE read in cycle 10 after release
        repeat (10) step(1'b0, 1'b0, 32'd0, 32'd0, 8'd0, got);
        step(1'b1, 1'b0, A_CYC, 32'd0, 8'd0, got);
        check("cycle_at_10", got, CYC_EN ? 32'd10 : 32'd0);
        @(negedge clk);
        check("cycle_err", {30'd0, dut.err_reg}, CYC_EN ? 32'd0 : 32'd2);
        @(posedge clk);
        m_commit(1'b1, 1'b0, A_CYC, 32'd0, 8'd0);
        #1;
        step(1'b0, 1'b1, A_ERR, 32'h3, 8'd0, got);

        // Fill RAM with known contents
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b1, A_RAM + 32'(4 * i), 32'h1000_0000 + 32'(i), 8'd0, got);
        end

        // Directed vectors
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, 8'd0, got);
            if (tbl[i].rd) check($sformatf("vec%0d", i), got, tbl[i].exp);
        end
        check("gpio_out_a5", {24'd0, gpio_out}, 32'hA5);

        // GPIO_IN synchroniser latency
        step(1'b1, 1'b0, A_GIN, 32'd0, 8'h00, got);
        step(1'b1, 1'b0, A_GIN, 32'd0, 8'h3C, got);
        check("gin_edge0", got, 32'h00);
        step(1'b1, 1'b0, A_GIN, 32'd0, 8'h3C, got);
        check("gin_edge1", got, 32'h00);
        step(1'b1, 1'b0, A_GIN, 32'd0, 8'h3C, got);
        check("gin_edge2", got, 32'h3C);

        // Reset asserted during a GPIO_OUT write aborts it
        memread = 1'b0; memwrite = 1'b1; data_address = A_GOUT; writedata = 32'hFF;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_abort_gpio", {24'd0, gpio_out}, 32'd0);
        memwrite = 1'b0;
        m_reset();
        reset = 1'b0;
        step(1'b1, 1'b0, A_CYC, 32'd0, 8'h3C, got);
        check("rst_cycle", got, 32'd0);
        step(1'b0, 1'b1, A_ERR, 32'h3, 8'h3C, got);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, wd;
            int sel;
            sel = int'($urandom_range(0, 9));
            wd = $urandom;
            case (sel)
                0, 1, 2, 3, 4: a = A_RAM + 32'(4 * $urandom_range(0, 63));
                5: a = A_RAM + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
                6: a = 32'h1000_0024 + 32'(4 * $urandom_range(0, 3));
                7: begin a = A_ERR; wd = {30'd0, 2'($urandom_range(0, 3))}; end
                8: a = $urandom;
                default: a = ($urandom_range(0, 1) != 0) ? A_RAM + 32'd256 : A_RAM - 32'd4;
            endcase
            gin_now = 8'($urandom);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd, gin_now, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
